// File: rtl/pipe_adder_pkg.sv
// Shared constants and stage-record types for the pipelined add/subtract unit.
package pipe_adder_pkg;

    localparam logic ADDER_OP_ADD = 1'b0;
    localparam logic ADDER_OP_SUB = 1'b1;

    // Control part of a stage record; data part is typedef'd inside the stage module.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-wide registered add stage with carry chain, valid/ready handshake
// and an opaque forwarded payload for the chunks other stages own.
module adder_chunk_stage
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int PW    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic [PW-1:0]    fwd_in,
    output logic             valid,
    input  logic             down_ready,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic [PW-1:0]    fwd_out
);
    typedef struct packed {
        logic [CHUNK-1:0] sum;
        logic [PW-1:0]    fwd;
    } stage_data_t;

    stage_ctl_t     ctl;
    stage_data_t    data;
    logic [CHUNK:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // Empty stage always accepts, which is what collapses bubbles.
    assign up_ready = !ctl.valid || down_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl <= '0;
        end else if (up_ready) begin
            ctl.valid <= up_valid;
            if (up_valid) ctl.carry <= total[CHUNK];
        end
    end

    always_ff @(posedge clock) begin
        if (up_ready && up_valid) data <= '{sum: total[CHUNK-1:0], fwd: fwd_in};
    end

    assign valid   = ctl.valid;
    assign cout    = ctl.carry;
    assign sum     = data.sum;
    assign fwd_out = data.fwd;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK per stage, valid/ready with backpressure.
// Optional signed-overflow output under RVSIMPLE_PIPE_ADDER_OVERFLOW_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] adder_result,
    output logic             carry_out
`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
    ,
    output logic             out_overflow
`endif
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int PW    = 3 * WIDTH;

    logic [STAGES-1:0]            vld;
    logic [STAGES:0]              rdy;
    logic [STAGES-1:0]            st_c;
    logic [STAGES-1:0][CHUNK-1:0] st_sum;
    logic [STAGES-1:0][PW-1:0]    st_fwd;
    logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_res;
    logic [WIDTH-1:0]             b_eff;

    assign b_eff    = (in_sub == ADDER_OP_ADD) ? operand_b : ~operand_b;
    assign rdy[STAGES] = out_ready;
    assign in_ready = rdy[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] a_up, b_up, r_up, r_here;
        logic             v_up, c_up;

        if (g == 0) begin : g_head
            assign a_up = operand_a;
            assign b_up = b_eff;
            assign r_up = '0;
            assign v_up = in_valid;
            assign c_up = in_sub;
        end else begin : g_body
            assign a_up = st_a[g-1];
            assign b_up = st_b[g-1];
            assign r_up = st_res[g-1];
            assign v_up = vld[g-1];
            assign c_up = st_c[g-1];
        end

        adder_chunk_stage #(.CHUNK(CHUNK), .PW(PW)) u_stage (
            .clock      (clock),
            .reset      (reset),
            .up_valid   (v_up),
            .up_ready   (rdy[g]),
            .a          (a_up[g*CHUNK +: CHUNK]),
            .b          (b_up[g*CHUNK +: CHUNK]),
            .cin        (c_up),
            .fwd_in     ({a_up, b_up, r_up}),
            .valid      (vld[g]),
            .down_ready (rdy[g+1]),
            .sum        (st_sum[g]),
            .cout       (st_c[g]),
            .fwd_out    (st_fwd[g])
        );

        // Splice this stage's resolved chunk into the forwarded partial result.
        always_comb begin
            r_here                      = st_fwd[g][WIDTH-1:0];
            r_here[g*CHUNK +: CHUNK]    = st_sum[g];
        end

        assign st_a[g]   = st_fwd[g][PW-1 -: WIDTH];
        assign st_b[g]   = st_fwd[g][2*WIDTH-1 -: WIDTH];
        assign st_res[g] = r_here;
    end

    assign out_valid    = vld[STAGES-1];
    assign adder_result = out_valid ? st_res[STAGES-1] : '0;
    assign carry_out    = out_valid & st_c[STAGES-1];

`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
    logic a_msb, b_msb, r_msb;
    assign a_msb        = st_a[STAGES-1][WIDTH-1];
    assign b_msb        = st_b[STAGES-1][WIDTH-1];
    assign r_msb        = st_res[STAGES-1][WIDTH-1];
    assign out_overflow = out_valid && (a_msb == b_msb) && (r_msb != a_msb);
`endif

    // Operand chunks leaving the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{st_a[STAGES-1], st_b[STAGES-1]};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner ops, stall/bubble/reset
// scenarios and a randomized phase against a queue-based reference model.
module tb_pipe_adder;
    localparam int W = 32;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic         clock, reset, in_valid, in_ready, in_sub, out_valid, out_ready, carry_out;
    logic [W-1:0] operand_a, operand_b, adder_result;
`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
    logic         out_overflow;
`endif

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub       (in_sub),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .adder_result (adder_result),
        .carry_out    (carry_out)
`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
        ,
        .out_overflow (out_overflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic fire_in, fire_out;
    int   out_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t   e;
        longint ua, ub, sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            e.r = W'(ua + ub);
            e.c = (ua + ub) >= (64'd1 << W);
            sr  = sa + sb;
        end else begin
            e.r = W'(ua - ub);
            e.c = ua >= ub;
            sr  = sa - sb;
        end
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic new_op();
        logic [W-1:0] corners [4];
        corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        operand_a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        operand_b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        in_sub    = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample handshakes on the falling edge, compare, then advance.
    task automatic cycle();
        @(negedge clock);
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
        if (out_valid) begin
            out_seen++;
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("out_result", adder_result, q[0].r);
                check("out_carry", carry_out, q[0].c);
`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
                check("out_ovf", out_overflow, q[0].o);
`endif
                if (fire_out) void'(q.pop_front());
            end
        end else begin
            check("gated_idle", {carry_out, adder_result}, 0);
        end
        if (fire_in) q.push_back(model(operand_a, operand_b, in_sub));
        @(posedge clock);
        #1;
    endtask

    task automatic one_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        operand_a = a;
        operand_b = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        cycle();
        check("one_accept", fire_in, 1);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check("latency", lat, S);
        check("direct_result", adder_result, er);
        check("direct_carry", carry_out, ec);
`ifdef RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
        check("direct_ovf", out_overflow, eo);
`else
        if (eo === 1'bx) check("direct_ovf_x", eo, 0);
`endif
        cycle();
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            cycle();
            k++;
        end
        check("drained", q.size(), 0);
    endtask

    initial begin
        int accepted;
        int k;
        reset = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        operand_a = '0; operand_b = '0; out_seen = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", adder_result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed corner operations.
        one_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        one_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        one_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Stream 8 ops into a stalled output: exactly S fit, then in_ready drops.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        new_op();
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (fire_in) begin accepted++; new_op(); end
        end
        check("stall_accepted", accepted, S);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        k = 0;
        while (accepted < 8 && k < 40) begin
            cycle();
            if (fire_in) begin accepted++; new_op(); end
            k++;
        end
        check("stream_accepted", accepted, 8);
        drain();

        // Bubble collapse: second op closes up behind a stalled first op.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_op();
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bub_first_out", out_valid, 1);
        in_valid = 1'b1;
        new_op();
        check("bub_in_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bub_room_left", in_ready, 1);
        out_ready = 1'b1;
        cycle();
        check("bub_behind", out_valid, 1);
        check("bub_one_left", q.size(), 1);
        cycle();
        check("bub_done", q.size(), 0);

        // Randomized traffic with random backpressure.
        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = (accepted < 150) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (fire_in) accepted++;
            new_op();
        end
        drain();

        // Reset with ops in flight: outputs drop at once, nothing stale afterwards.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin new_op(); cycle(); end
        in_valid = 1'b0;
        cycle();
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", adder_result, 0);
        check("midrst_carry", carry_out, 0);
        q.delete();
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        out_seen  = 0;
        repeat (10) cycle();
        check("post_rst_stale", out_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit for rvsimple datapaths that need wide operands at high clock rate, such as multi-cycle ALU extensions and address generation.
- Splits a WIDTH-bit operation into STAGES equal chunks; each pipeline stage resolves one chunk and registers the carry to the next stage.
- valid/ready handshake on input and output, with full backpressure and bubble collapse.
- Successor to the single-cycle combinational adder.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4: pipeline depth, which is also the number of chunks. Must satisfy 1 <= STAGES <= WIDTH.
- CHUNK, WIDTH/STAGES: derived chunk width. Localparam, not overridable.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline valid bits
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept an input this cycle
- in_sub  in  1  0 = a+b, 1 = a-b
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- adder_result  out  WIDTH  sum/difference modulo 2^WIDTH
- carry_out  out  1  carry out of the MSB; for subtract, 1 = no borrow
- out_overflow  out  1  signed overflow (present only with the optional feature)

Behaviour:
- Reset (async assert, sync deassert in the system): all stage valid bits = 0, so out_valid = 0.
  - Data registers are don't-care.
  - adder_result and carry_out drive 0 while out_valid = 0; they are gated, not just X.
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
- Stage i (0..STAGES-1) holds valid[i], the remaining operand chunks, the resolved result chunks 0..i, and the carry out of chunk i.
- Per-stage ready rules:
  - ready[i] = !valid[i] | ready[i+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0], which is combinational from out_ready through the valid chain.
  - A stage whose ready is 0 holds its contents unchanged.
- Stage 0 arithmetic on capture:
  - b' = in_sub ? ~operand_b : operand_b
  - cin = in_sub
  - chunk0 = a[CHUNK-1:0] + b'[CHUNK-1:0] + cin, CHUNK+1 bits
  - The top bit is the carry.
- Stage i > 0 arithmetic: chunk i = a_i + b'_i + carry from stage i-1.
  - Lower result chunks are forwarded unchanged.
  - Upper operand chunks (already inverted for subtract) are forwarded unchanged.
- Output side:
  - adder_result is the concatenation of all chunks in stage STAGES-1.
  - carry_out is the carry of the last chunk.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall.
- Throughput: 1 operation per cycle while out_ready = 1.
- Bubble collapse: an empty stage accepts from upstream even while a later stage is stalled.
- Ordering: strictly in order, no reordering or dropping.
- STAGES = 1: degenerates to a single registered adder with a one-deep skid.
  - in_ready = !out_valid | out_ready.
- Simultaneous output pop and input push on a full pipeline: allowed, all stages advance.
- Wrap-around: results are modulo 2^WIDTH, reported via carry_out.
- Reset asserted mid-operation: all in-flight operations are discarded immediately and out_valid drops asynchronously.

Optional Feature:
- Macro: RVSIMPLE_PIPE_ADDER_OVERFLOW_EN
- Defined:
  - Port out_overflow exists.
  - The last stage registers the sign bits of a and b' and computes overflow = (a_msb == b'_msb) & (res_msb != a_msb).
  - out_overflow is valid with out_valid and is 0 otherwise or after reset.
- Undefined:
  - Port and sign-tracking flops are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package (constants.sv alongside the existing constants):
  - localparam ADDER_OP_ADD = 1'b0, ADDER_OP_SUB = 1'b1
  - stage-record typedef helper for the chunk/carry/valid fields, parametrised by CHUNK through module-local typedef
- One sub-module, adder_chunk_stage:
  - a single CHUNK-wide registered add stage with carry-in, carry-out, valid and ready.
  - Instantiated STAGES times by a generate loop.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1, a=0x0000_00FF, b=0x0000_0001, add -> after exactly 4 cycles adder_result=0x0000_0100, carry_out=0. This exercises carry across chunk 0→1.
- a=0xFFFF_FFFF, b=0x0000_0001, add -> result 0x0000_0000, carry_out=1. With the feature enabled, out_overflow=0.
- a=0x0000_0005, b=0x0000_0007, sub -> result 0xFFFF_FFFE, carry_out=0 (borrow). Also a=0x8000_0000, b=1, sub -> 0x7FFF_FFFF with out_overflow=1.
- Back-to-back stream of 8 ops, then hold out_ready=0 for 5 cycles -> in_ready falls after the pipeline fills (4 ops held). Results emerge in order, with no loss or duplication, when out_ready returns to 1.
- Issue 1 op, stall the output 3 cycles, then issue a 2nd op -> the 2nd op advances through empty stages and sits directly behind the 1st (bubble collapse).
- Reset pulse asserted with 3 ops in flight -> out_valid=0 and adder_result=0 within the same cycle. No stale result appears after reset is released.
